// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment scan controller
package seg_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  localparam int DEF_DIGITS = 4;
  localparam int DEF_SLOT_CYC = 50000;
  localparam int DEF_BLANK_CYC = 2;
  localparam int NIBBLE_W = 4;
  localparam logic SEG_ON = 1'b0;
  localparam logic SEG_OFF = 1'b1;
endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: per-slot cycle counter and digit index with slot-end/frame strobes
// Ports: clk, rst; act (scanning state), clr (force counters to zero);
//        cnt (cycle within slot), idx (digit), slot_end (last cycle of slot), frame (last cycle of last digit)
module seg_slot_timer import seg_pkg::*; #(
  parameter int DIGITS = DEF_DIGITS,
  parameter int SLOT_CYC = DEF_SLOT_CYC,
  parameter int CNT_W = 16,
  parameter int IDX_W = $clog2(DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output logic             slot_end,
  output logic             frame
);
  logic last_cnt, last_idx;
  assign last_cnt = cnt == CNT_W'(SLOT_CYC - 1);
  assign last_idx = idx == IDX_W'(DIGITS - 1);
  assign slot_end = act && last_cnt;
  assign frame = slot_end && last_idx;
  // compare before incrementing so cnt never overflows
  always_ff @(posedge clk)
    if (rst || clr || !act) begin
      cnt <= '0;
      idx <= '0;
    end else if (last_cnt) begin
      cnt <= '0;
      idx <= last_idx ? '0 : idx + 1'b1;
    end else
      cnt <= cnt + 1'b1;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed common-anode 7-segment scan controller
// Ports: clk, rst (sync, active-high); en (scan enable); value/dp_in/load (double-buffered input);
//        hex (registered nibble to external decoder), dig_n (active-low anodes), dp_n, frame (end-of-frame pulse)
// Optional: define SEG_LZ_SUPPRESS_EN for leading-zero suppression.
module seg_scan_ctrl import seg_pkg::*; #(
  parameter int DIGITS = DEF_DIGITS,
  parameter int SLOT_CYC = DEF_SLOT_CYC,
  parameter int BLANK_CYC = DEF_BLANK_CYC,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NIBBLE_W*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]          dp_in,
  input  logic                       load,
  output logic [NIBBLE_W-1:0]        hex,
  output logic [DIGITS-1:0]          dig_n,
  output logic                       dp_n,
  output logic                       frame
);
  localparam int IDX_W = $clog2(DIGITS);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx, idx_nx;
  logic slot_end, start, swap, pv, lit;
  logic [NIBBLE_W*DIGITS-1:0] pend, disp, pend_nx, disp_nx;
  logic [DIGITS-1:0] pdp, ddp, pdp_nx, ddp_nx, lz;

  seg_slot_timer #(.DIGITS(DIGITS), .SLOT_CYC(SLOT_CYC), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_timer (
    .clk(clk), .rst(rst), .act(state != IDLE), .clr(!en),
    .cnt(cnt), .idx(idx), .slot_end(slot_end), .frame(frame)
  );

  // start marks the edge that enters cnt=0 of a slot; swap refreshes the display at digit-0 entry,
  // taking a coincident load directly so it is shown this frame
  assign idx_nx = (state == IDLE || idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
  assign start = en && (state == IDLE || slot_end);
  assign swap = start && idx_nx == '0 && (pv || load);
  assign pend_nx = load ? value : pend;
  assign pdp_nx = load ? dp_in : pdp;
  assign disp_nx = swap ? pend_nx : disp;
  assign ddp_nx = swap ? pdp_nx : ddp;

`ifdef SEG_LZ_SUPPRESS_EN
  logic z;
  // digit i is blank when it and every digit above it has a zero nibble and no dp
  always_comb begin
    z = 1'b1;
    lz = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z && disp[NIBBLE_W*i +: NIBBLE_W] == '0 && !ddp[i];
      lz[i] = z;
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    state_nx = state;
    lit = state == SHOW && !lz[idx];
    dig_n = lit ? ~(DIGITS'(1) << idx) : {DIGITS{SEG_OFF}};
    dp_n = lit ? ~ddp[idx] : SEG_OFF;
    if (!en)
      state_nx = IDLE;
    else if (state == IDLE)
      state_nx = BLANK;
    else if (state == BLANK && cnt == CNT_W'(BLANK_CYC - 1))
      state_nx = SHOW;
    else if (state == SHOW && slot_end)
      state_nx = BLANK;
  end

  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      hex <= '0;
      pend <= '0;
      pdp <= '0;
      disp <= '0;
      ddp <= '0;
      pv <= 1'b0;
    end else begin
      state <= state_nx;
      pend <= pend_nx;
      pdp <= pdp_nx;
      disp <= disp_nx;
      ddp <= ddp_nx;
      pv <= swap ? 1'b0 : (pv || load);
      if (start)
        hex <= disp_nx[{idx_nx, 2'b00} +: NIBBLE_W];
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (DIGITS=4, SLOT_CYC=8, BLANK_CYC=2)
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst, en, load;
  logic [15:0] value;
  logic [3:0] dp_in, hex, dig_n;
  logic dp_n, frame;
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  logic done = 1'b0;

`ifdef SEG_LZ_SUPPRESS_EN
  localparam logic [3:0] LZ0 = 4'b0001;
  localparam logic [3:0] LZ40 = 4'b0011;
`else
  localparam logic [3:0] LZ0 = 4'b1111;
  localparam logic [3:0] LZ40 = 4'b1111;
`endif

  typedef struct {
    int cyc;
    logic hc;
    logic [3:0] hex;
    logic [3:0] dig;
    logic dp;
    logic fr;
  } exp_t;
  exp_t q[$];

  seg_scan_ctrl #(.DIGITS(4), .SLOT_CYC(8), .BLANK_CYC(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .value(value), .dp_in(dp_in), .load(load),
    .hex(hex), .dig_n(dig_n), .dp_n(dp_n), .frame(frame)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_dark(input int c, input logic hc, input logic [3:0] h);
    q.push_back('{cyc: c, hc: hc, hex: h, dig: 4'hF, dp: 1'b1, fr: 1'b0});
  endtask

  // one digit slot: anodes off for cnt 0-1, digit d on for cnt 2-7, frame on cnt 7 of digit 3
  task automatic push_slot(input int c0, input int d, input logic [3:0] nib, input logic dpb,
                           input logic lit, input int n);
    logic dark;
    for (int k = 0; k < n; k++) begin
      dark = k < 2 || !lit;
      q.push_back('{cyc: c0 + k, hc: 1'b1, hex: nib, dig: dark ? 4'hF : ~(4'b0001 << d),
                    dp: dark ? 1'b1 : ~dpb, fr: d == 3 && k == 7});
    end
  endtask

  task automatic push_frame(input int c0, input logic [15:0] v, input logic [3:0] dp, input logic [3:0] lit);
    for (int d = 0; d < 4; d++)
      push_slot(c0 + 8*d, d, v[4*d +: 4], dp[d], lit[d], 8);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL stale cyc=%0d expected entry for cyc=%0d never sampled", cyc, e.cyc);
      end else if (dig_n !== e.dig || dp_n !== e.dp || frame !== e.fr || (e.hc && hex !== e.hex)) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d got hex=%h dig_n=%b dp_n=%b frame=%b want hex=%h(chk %0b) dig_n=%b dp_n=%b frame=%b",
                 cyc, hex, dig_n, dp_n, frame, e.hex, e.hc, e.dig, e.dp, e.fr);
      end
    end
    if (done) begin
      if (q.size() != 0) begin
        n_bad++;
        $display("FAIL drain cyc=%0d got %0d pending entries want 0", cyc, q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got no summary by t=100000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp_in = '0;
    tick(3);
    push_dark(3, 1'b1, 4'h0);
    rst = 1'b0; en = 1'b1; load = 1'b1; value = 16'h1234;
    tick(1); load = 1'b0;
    push_frame(4, 16'h1234, 4'b0000, 4'hF);
    push_frame(36, 16'h1234, 4'b0000, 4'hF);
    tick(50);
    load = 1'b1; value = 16'hABCD;
    tick(1); load = 1'b0;
    push_frame(68, 16'hABCD, 4'b0000, 4'hF);
    tick(44);
    load = 1'b1; value = 16'h5678; dp_in = 4'b0100;
    tick(1); load = 1'b0; dp_in = 4'b0000;
    push_frame(100, 16'h5678, 4'b0100, 4'hF);
    push_slot(132, 0, 4'h8, 1'b0, 1'b1, 8);
    push_slot(140, 1, 4'h7, 1'b0, 1'b1, 6);
    tick(45);
    en = 1'b0;
    tick(1);
    push_dark(146, 1'b0, 4'h0);
    push_dark(147, 1'b0, 4'h0);
    tick(1); en = 1'b1;
    push_frame(148, 16'h5678, 4'b0100, 4'hF);
    push_slot(180, 0, 4'h8, 1'b0, 1'b1, 4);
    push_dark(184, 1'b1, 4'h0);
    tick(36);
    rst = 1'b1;
    tick(1); rst = 1'b0;
    push_frame(185, 16'h0000, 4'b0000, LZ0);
    tick(32);
    load = 1'b1; value = 16'h0040;
    tick(1); load = 1'b0;
    push_frame(217, 16'h0040, 4'b0000, LZ40);
    tick(34);
    done = 1'b1;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
- Shares one registered hex-to-segment decoder (1-cycle latency, active-low segments) across DIGITS digits.
- Drives that decoder's nibble input, the digit anode enables and the decimal point.
- Inserts a blanking interval per slot to hide decoder latency and prevent ghosting; double-buffers the displayed value so frames never tear.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
SLOT_CYC, 50000, clk cycles per digit slot (>= BLANK_CYC+1)
BLANK_CYC, 2, cycles at slot start with all anodes off (>= 2, covers decoder latency)
CNT_W, 16, slot counter width; must satisfy 2**CNT_W >= SLOT_CYC

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  scan enable; 0 = display dark, scan held
value  in  4*DIGITS  digit nibbles; value[3:0] = digit 0 (rightmost)
dp_in  in  DIGITS  decimal point request per digit, 1 = lit
load  in  1  one-cycle strobe: capture value/dp_in into pending buffer
hex  out  4  nibble to shared decoder, registered
dig_n  out  DIGITS  anode enables, active-low, one-hot-low or all ones
dp_n  out  1  decimal point, active-low, aligned with dig_n
frame  out  1  one-cycle pulse on last cycle of digit DIGITS-1 slot

Behaviour:
- Reset values: hex=0, dig_n=all ones, dp_n=1, frame=0, slot counter cnt=0, digit index idx=0, pending and display buffers=0, pending_valid=0, state=IDLE.
- State machine:
  - IDLE: outputs dark, cnt=0, idx=0. Goes to BLANK when en=1.
  - BLANK: cnt < BLANK_CYC; dig_n all ones, dp_n=1. Goes to SHOW when cnt == BLANK_CYC-1.
  - SHOW: cnt in [BLANK_CYC, SLOT_CYC-1]; dig_n[idx]=0, all others 1; dp_n = ~display_dp[idx]. At cnt == SLOT_CYC-1: cnt goes to 0, idx advances (DIGITS-1 wraps to 0), state goes to BLANK.
- en=0 in any state: IDLE on the next cycle; dig_n all ones and dp_n=1 from that cycle; cnt and idx cleared. Pending buffer is retained.
- Nibble timing:
  - hex is registered with display_value nibble idx on the cycle entering cnt=0 of each slot.
  - The decoder output is valid from cnt=1, so it is stable before the anode turns on at cnt=BLANK_CYC.
- Buffering:
  - load=1 captures value/dp_in into pending and sets pending_valid.
  - At entry to slot idx=0 (cnt=0), if pending_valid: display<=pending and pending_valid<=0.
  - load coincident with the idx-0 slot start: the newly loaded value is the one copied (bypass).
  - Multiple loads within a frame: last one wins.
- frame is asserted when state=SHOW, idx=DIGITS-1 and cnt=SLOT_CYC-1. It is never asserted in IDLE.
- Digit rate = f_clk/SLOT_CYC; refresh rate = f_clk/(SLOT_CYC*DIGITS). No arithmetic overflow: cnt compares against SLOT_CYC-1 before incrementing.
- rst mid-slot: all outputs return to reset values on the next edge, regardless of en.

Optional Feature:
- Macro: SEG_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression. Digit k (k >= 1) is blanked when display nibbles k..DIGITS-1 are all zero and dp for digits k..DIGITS-1 is 0. Blanked means its anode stays off during SHOW and dp_n=1. Digit 0 is never blanked, so value 0 shows a single "0". Example: 0x0040 shows "40" on digits 1..0.
- Not defined: all digits are always shown, including leading zeros.

Decomposition:
- Package seg_pkg:
  - state enum {IDLE, BLANK, SHOW}
  - default DIGITS, SLOT_CYC and BLANK_CYC constants
  - NIBBLE_W=4
  - active-low polarity constants SEG_ON=0, SEG_OFF=1
- Sub-module seg_slot_timer: cnt and idx counters plus the slot-end/frame strobes. seg_scan_ctrl keeps the FSM, buffers and output registers.
- The decoder stays external, driven from hex.

Test Plan:
Use DIGITS=4, SLOT_CYC=8, BLANK_CYC=2.
1. Reset then en=1, load value=0x1234 -> display copied at first idx-0 slot. Per slot: hex=4,3,2,1. dig_n=1111 for cnt 0-1, then 1110/1101/1011/0111 for cnt 2-7. frame pulses every 32 cycles.
2. Blanking/latency: check each slot -> hex changes only at cnt=0, dig_n all ones at cnt 0-1, no anode low in the cycle where hex changes.
3. load=0xABCD mid-frame while idx=2 -> digits 2,3 of the current frame still show 0x1234. Next frame shows D,C,B,A. load coincident with idx-0 slot start -> new value shown that frame.
4. en dropped at idx=1, cnt=5 -> next cycle dig_n=1111, dp_n=1, cnt=0, idx=0. Re-enable -> scanning restarts at digit 0 with BLANK.
5. dp_in=0b0100 loaded -> dp_n=0 only during the SHOW cycles of digit 2. rst asserted mid-SHOW -> all outputs at reset values the next cycle.
6. With SEG_LZ_SUPPRESS_EN: value=0x0040, dp=0 -> digits 3,2 stay dark, digits 1,0 scan normally. value=0x0000 -> only digit 0 lit, hex=0.
